lfsr_checker: RTL and testbench
===============================

// Module: lfsr_checker
// PURPOSE
// Receive-side counterpart of the 5-bit LFSR pattern generator. Consumes the
// serial stream taken from the generator's q[0] and self-synchronises a local
// copy of the same LFSR. After lock it predicts every bit, flags mismatches and
// counts errors. On persistent error it drops lock and re-acquires.
// PARAMETERS
// N           5   LFSR length; history register width
// TAP         2   second feedback tap; recurrence s[t+N] = s[t] ^ s[t+TAP]
// WINDOW      32  accepted bits per loss-of-lock evaluation window (>=2)
// ERR_THRESH  4   mismatches within one WINDOW that force loss of lock (>=1)
// CNT_W       16  width of the error counter
// PORTS
// clk         in   1      single clock; all state changes on rising edge
// reset       in   1      synchronous, active-high
// in_valid    in   1      in_bit is accepted on this cycle
// in_bit      in   1      received pattern bit
// clear_count in   1      synchronous clear of err_count
// locked      out  1      checker is synchronised (registered level)
// bit_err     out  1      1-cycle pulse: accepted bit mismatched prediction
// lock_lost   out  1      1-cycle pulse: threshold reached, lock dropped
// stuck_zero  out  1      level: last acquisition captured all-zero history
// err_count   out  CNT_W  saturating count of mismatches since reset/clear
// BEHAVIOUR
// - Reset (synchronous): state=ACQUIRE; fill, window and window-error counts=0;
//   history h=0; all outputs=0. Reset applies mid-LOCKED and mid-ACQUIRE alike.
// - in_valid=0: no state, counter, or history change; bit_err/lock_lost low.
// - h[N-1:0]: h[0] is the oldest bit. The shift is h <= {new, h[N-1:1]}.
// - ACQUIRE: each accepted bit shifts in_bit into h and increments fill.
//   * On the Nth accepted bit: if {in_bit, h[N-1:1]} is all zero, set
//     stuck_zero=1, set fill=0, and stay in ACQUIRE.
//   * Otherwise, go to LOCKED. locked=1 from the next cycle. Window counts=0.
//   * stuck_zero clears on any accepted in_bit=1.
//   * No error checking occurs in ACQUIRE.
// - LOCKED: predicted p = h[0] ^ h[TAP]. h shifts in p, not in_bit
//   (free-running), so one corrupted bit gives exactly one mismatch.
//   * If in_bit != p: bit_err=1 on the next cycle, err_count+1 (saturate at
//     all-ones), and window-error count +1.
//   * Window counter counts accepted bits. At the WINDOW-th bit it wraps to 0
//     and the window-error count clears.
//   * When the window-error count reaches ERR_THRESH: lock_lost=1 for one
//     cycle, locked=0, go to ACQUIRE with fill=0. The error is still counted.
//     Threshold takes priority over a coincident window wrap.
// - Latency: outputs update on the edge that accepts the bit and are visible
//   the following cycle. Back-to-back in_valid is supported at full rate.
// - clear_count: err_count <= 0. This has priority over a coincident error,
//   which is then not counted in err_count but still counts toward the window.
// - Error counting and window logic are active only while locked.
// TESTING
// 1. Seed 5'b00001 stream (1,0,0,0,0,1,0,0,1,0,...), continuous valid ->
//    locked=1 the cycle after the 5th bit; 62 further bits give err_count=0.
// 2. Same stream, invert locked bit #10 -> exactly one bit_err pulse,
//    err_count=1, locked stays 1, and later bits are clean.
// 3. Invert 4 bits within one 32-bit window -> lock_lost pulse on the 4th
//    error, locked=0; locked=1 again after 5 clean bits. err_count=4.
// 4. 3 errors in window 1 plus 3 in window 2 -> no lock_lost, err_count=6.
// 5. All-zero stream -> stuck_zero=1 after 5 bits, locked never rises. Then
//    a valid pattern -> stuck_zero=0 and lock acquired.
// 6. in_valid every 3rd cycle with test 2 data -> identical err_count. Then
//    reset while LOCKED -> all outputs 0 on the next cycle; clear_count
//    coincident with an error -> err_count=0.

Source files
------------

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - self-synchronising checker for the 5-bit LFSR pattern stream
// Acquires history from the received bits, then free-runs its own LFSR and counts mismatches.
module lfsr_checker #(
  parameter int N          = 5,
  parameter int TAP        = 2,
  parameter int WINDOW     = 32,
  parameter int ERR_THRESH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clear_count,
  output logic             locked,
  output logic             bit_err,
  output logic             lock_lost,
  output logic             stuck_zero,
  output logic [CNT_W-1:0] err_count
);

  localparam int FW = $clog2(N + 1);
  localparam int WW = $clog2(WINDOW);
  localparam int EW = $clog2(ERR_THRESH + 1);
  localparam logic [FW-1:0] FILL_LAST  = FW'(N - 1);
  localparam logic [WW-1:0] WIN_LAST   = WW'(WINDOW - 1);
  localparam logic [EW-1:0] THRESH_M1  = EW'(ERR_THRESH - 1);

  typedef enum logic {
    ST_ACQUIRE = 1'b0,
    ST_LOCKED  = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [N-1:0]     r_h, w_h_nxt;
  logic [FW-1:0]    r_fill, w_fill_nxt;
  logic [WW-1:0]    r_win, w_win_nxt;
  logic [EW-1:0]    r_werr, w_werr_nxt;
  logic             r_locked, w_locked_nxt;
  logic             r_bit_err, w_bit_err_nxt;
  logic             r_lock_lost, w_lock_lost_nxt;
  logic             r_stuck_zero, w_stuck_zero_nxt;
  logic [CNT_W-1:0] r_err_count, w_err_count_nxt;

  logic             w_pred;
  logic [N-1:0]     w_shift_in;

  assign w_pred     = r_h[0] ^ r_h[TAP];
  assign w_shift_in = {in_bit, r_h[N-1:1]};

  always_comb begin
    w_state_nxt      = r_state;
    w_h_nxt          = r_h;
    w_fill_nxt       = r_fill;
    w_win_nxt        = r_win;
    w_werr_nxt       = r_werr;
    w_locked_nxt     = r_locked;
    w_bit_err_nxt    = 1'b0;
    w_lock_lost_nxt  = 1'b0;
    w_stuck_zero_nxt = r_stuck_zero;
    w_err_count_nxt  = r_err_count;

    if (clear_count) begin
      w_err_count_nxt = '0;
    end

    if (in_valid) begin
      if (in_bit) begin
        w_stuck_zero_nxt = 1'b0;
      end
      case (r_state)
        ST_ACQUIRE: begin
          w_h_nxt = w_shift_in;
          if (r_fill == FILL_LAST) begin
            w_fill_nxt = '0;
            if (w_shift_in == '0) begin
              w_stuck_zero_nxt = 1'b1;
            end else begin
              w_state_nxt  = ST_LOCKED;
              w_locked_nxt = 1'b1;
              w_win_nxt    = '0;
              w_werr_nxt   = '0;
            end
          end else begin
            w_fill_nxt = r_fill + 1'b1;
          end
        end
        default: begin
          // Free-running: the prediction, not the received bit, feeds history.
          w_h_nxt = {w_pred, r_h[N-1:1]};
          if (r_win == WIN_LAST) begin
            w_win_nxt  = '0;
            w_werr_nxt = '0;
          end else begin
            w_win_nxt = r_win + 1'b1;
          end
          if (in_bit != w_pred) begin
            w_bit_err_nxt = 1'b1;
            if (!clear_count && (r_err_count != '1)) begin
              w_err_count_nxt = r_err_count + 1'b1;
            end
            if (r_werr == THRESH_M1) begin
              w_lock_lost_nxt = 1'b1;
              w_locked_nxt    = 1'b0;
              w_state_nxt     = ST_ACQUIRE;
              w_fill_nxt      = '0;
              w_win_nxt       = '0;
              w_werr_nxt      = '0;
            end else if (r_win != WIN_LAST) begin
              w_werr_nxt = r_werr + 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_ACQUIRE;
      r_h          <= '0;
      r_fill       <= '0;
      r_win        <= '0;
      r_werr       <= '0;
      r_locked     <= 1'b0;
      r_bit_err    <= 1'b0;
      r_lock_lost  <= 1'b0;
      r_stuck_zero <= 1'b0;
      r_err_count  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_h          <= w_h_nxt;
      r_fill       <= w_fill_nxt;
      r_win        <= w_win_nxt;
      r_werr       <= w_werr_nxt;
      r_locked     <= w_locked_nxt;
      r_bit_err    <= w_bit_err_nxt;
      r_lock_lost  <= w_lock_lost_nxt;
      r_stuck_zero <= w_stuck_zero_nxt;
      r_err_count  <= w_err_count_nxt;
    end
  end

  assign locked     = r_locked;
  assign bit_err    = r_bit_err;
  assign lock_lost  = r_lock_lost;
  assign stuck_zero = r_stuck_zero;
  assign err_count  = r_err_count;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - directed and randomized bench for lfsr_checker
// Reference model tracks the expected bit sequence as a list and applies the lock/window rules.
module tb_lfsr_checker;

  localparam int N          = 5;
  localparam int TAP        = 2;
  localparam int WINDOW     = 32;
  localparam int ERR_THRESH = 4;
  localparam int CNT_W      = 16;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_bit;
  logic             clear_count;
  logic             locked;
  logic             bit_err;
  logic             lock_lost;
  logic             stuck_zero;
  logic [CNT_W-1:0] err_count;

  lfsr_checker #(
    .N(N), .TAP(TAP), .WINDOW(WINDOW), .ERR_THRESH(ERR_THRESH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
    .clear_count(clear_count), .locked(locked), .bit_err(bit_err),
    .lock_lost(lock_lost), .stuck_zero(stuck_zero), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: the bit sequence the checker believes in, newest at the back.
  bit m_seq[$];
  bit m_locked, m_bit_err, m_lock_lost, m_stuck;
  int m_fill, m_win, m_werr, m_err;

  // Transmitter: generates the pattern bit stream from a seed.
  bit g_seq[$];

  int n_berr, n_ll;

  task automatic model_reset();
    m_seq.delete();
    for (int i = 0; i < N; i++) m_seq.push_back(1'b0);
    m_locked = 0; m_bit_err = 0; m_lock_lost = 0; m_stuck = 0;
    m_fill = 0; m_win = 0; m_werr = 0; m_err = 0;
  endtask

  task automatic model_step(input bit v, input bit b, input bit clr);
    int  sz;
    bit  p;
    bit  all_zero;
    m_bit_err   = 0;
    m_lock_lost = 0;
    if (clr) m_err = 0;
    if (v) begin
      if (b) m_stuck = 0;
      sz = m_seq.size();
      if (!m_locked) begin
        m_seq.push_back(b);
        m_fill++;
        if (m_fill == N) begin
          m_fill   = 0;
          all_zero = 1;
          for (int i = 0; i < N; i++) if (m_seq[sz + 1 - N + i]) all_zero = 0;
          if (all_zero) m_stuck = 1;
          else begin
            m_locked = 1; m_win = 0; m_werr = 0;
          end
        end
      end else begin
        p = m_seq[sz - N] ^ m_seq[sz - N + TAP];
        m_seq.push_back(p);
        m_win++;
        if (b != p) begin
          m_bit_err = 1;
          if (!clr && m_err < CNT_MAX) m_err++;
          m_werr++;
        end
        if (m_werr == ERR_THRESH) begin
          m_lock_lost = 1; m_locked = 0; m_fill = 0; m_win = 0; m_werr = 0;
        end else if (m_win == WINDOW) begin
          m_win = 0; m_werr = 0;
        end
      end
      while (m_seq.size() > N) void'(m_seq.pop_front());
    end
  endtask

  task automatic compare_all();
    chk("locked", 32'(locked), 32'(m_locked));
    chk("bit_err", 32'(bit_err), 32'(m_bit_err));
    chk("lock_lost", 32'(lock_lost), 32'(m_lock_lost));
    chk("stuck_zero", 32'(stuck_zero), 32'(m_stuck));
    chk("err_count", 32'(err_count), 32'(m_err));
  endtask

  task automatic step(input bit v, input bit b, input bit clr);
    in_valid    = v;
    in_bit      = b;
    clear_count = clr;
    @(posedge clk);
    model_step(v, b, clr);
    #1;
    if (bit_err) n_berr++;
    if (lock_lost) n_ll++;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; clear_count = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    reset = 1'b0;
    compare_all();
    n_berr = 0;
    n_ll   = 0;
  endtask

  task automatic gen_seed(input bit [N-1:0] seed);
    g_seq.delete();
    for (int i = 0; i < N; i++) g_seq.push_back(seed[i]);
  endtask

  task automatic gen_next(output bit b);
    b = g_seq[0];
    g_seq.push_back(g_seq[0] ^ g_seq[TAP]);
    void'(g_seq.pop_front());
  endtask

  task automatic send(input bit inv, input bit clr);
    bit b;
    gen_next(b);
    step(1'b1, b ^ inv, clr);
  endtask

  initial begin
    bit [N-1:0] seed;
    bit         v;
    bit         b;

    do_reset();
    chk("reset_locked", 32'(locked), 32'd0);
    chk("reset_err_count", 32'(err_count), 32'd0);

    // Test 1: clean stream, lock after 5 bits.
    gen_seed(5'b00001);
    for (int i = 1; i <= N; i++) begin
      send(1'b0, 1'b0);
      if (i == N - 1) chk("t1_not_locked_yet", 32'(locked), 32'd0);
    end
    chk("t1_locked", 32'(locked), 32'd1);
    for (int i = 0; i < 62; i++) send(1'b0, 1'b0);
    chk("t1_err_count", 32'(err_count), 32'd0);

    // Test 2: one corrupted bit after lock.
    do_reset();
    gen_seed(5'b00001);
    for (int i = 0; i < N; i++) send(1'b0, 1'b0);
    for (int k = 1; k <= 40; k++) send(k == 10, 1'b0);
    chk("t2_bit_err_pulses", 32'(n_berr), 32'd1);
    chk("t2_err_count", 32'(err_count), 32'd1);
    chk("t2_locked", 32'(locked), 32'd1);

    // Test 3: four errors in one window drop lock; reacquire on 5 clean bits.
    do_reset();
    gen_seed(5'b00001);
    for (int i = 0; i < N; i++) send(1'b0, 1'b0);
    for (int k = 0; k < 12; k++) send(k == 2 || k == 5 || k == 8 || k == 11, 1'b0);
    chk("t3_lock_lost_pulses", 32'(n_ll), 32'd1);
    chk("t3_unlocked", 32'(locked), 32'd0);
    for (int i = 1; i <= N; i++) begin
      send(1'b0, 1'b0);
      if (i == N - 1) chk("t3_not_relocked_yet", 32'(locked), 32'd0);
    end
    chk("t3_relocked", 32'(locked), 32'd1);
    chk("t3_err_count", 32'(err_count), 32'd4);

    // Test 4: three errors in each of two windows keep lock.
    do_reset();
    gen_seed(5'b00001);
    for (int i = 0; i < N; i++) send(1'b0, 1'b0);
    for (int k = 0; k < 70; k++) send(k inside {1, 2, 3, 40, 41, 42}, 1'b0);
    chk("t4_lock_lost_pulses", 32'(n_ll), 32'd0);
    chk("t4_err_count", 32'(err_count), 32'd6);
    chk("t4_locked", 32'(locked), 32'd1);

    // Test 5: all-zero stream reports stuck_zero, then a real pattern locks.
    do_reset();
    for (int i = 0; i < N; i++) step(1'b1, 1'b0, 1'b0);
    chk("t5_stuck_zero", 32'(stuck_zero), 32'd1);
    for (int i = 0; i < N; i++) step(1'b1, 1'b0, 1'b0);
    chk("t5_still_unlocked", 32'(locked), 32'd0);
    gen_seed(5'b00001);
    send(1'b0, 1'b0);
    chk("t5_stuck_cleared", 32'(stuck_zero), 32'd0);
    for (int i = 1; i < N; i++) send(1'b0, 1'b0);
    chk("t5_locked", 32'(locked), 32'd1);

    // Test 6: sparse valid, then reset while locked, then clear vs error.
    do_reset();
    gen_seed(5'b00001);
    for (int k = -N + 1; k <= 40; k++) begin
      send(k == 10, 1'b0);
      step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end
    chk("t6_sparse_err_count", 32'(err_count), 32'd1);
    chk("t6_sparse_locked", 32'(locked), 32'd1);
    do_reset();
    chk("t6_reset_locked", 32'(locked), 32'd0);
    chk("t6_reset_err_count", 32'(err_count), 32'd0);
    gen_seed(5'b10110);
    for (int i = 0; i < N + 3; i++) send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    chk("t6_err_before_clear", 32'(err_count), 32'd1);
    send(1'b1, 1'b1);
    chk("t6_clear_bit_err", 32'(bit_err), 32'd1);
    chk("t6_clear_err_count", 32'(err_count), 32'd0);

    // Randomized traffic against the model.
    do_reset();
    gen_seed(5'b00001);
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
      end
      if ($urandom_range(0, 399) == 0) begin
        seed = N'($urandom_range(1, (1 << N) - 1));
        gen_seed(seed);
      end
      v = ($urandom_range(0, 3) != 0);
      if (v) begin
        gen_next(b);
        if ($urandom_range(0, 24) == 0) b = ~b;
      end else begin
        b = 1'($urandom_range(0, 1));
      end
      step(v, b, $urandom_range(0, 199) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
